mac_share_arbiter: RTL

//   Time-shares one pipelined_mac (32x16-bit dot product + bias) between NUM_REQ layer engines
//   (e.g. discriminator layer 1/2/3 neuron sequencers) using round-robin arbitration.

---
 rtl/mac_share_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mac_share_arbiter.sv
// Round-robin time-sharing of a single pipelined MAC between NUM_REQ layer engines.
// Latches the winner's operands, issues a one-cycle start, and returns the result with a done pulse.
module mac_share_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int VEC_W   = 512,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*VEC_W-1:0]       req_a_flat,
    input  logic [NUM_REQ*VEC_W-1:0]       req_b_flat,
    input  logic [NUM_REQ*16-1:0]          req_bias,
    output logic [NUM_REQ-1:0]             done,
    output logic signed [15:0]             result,
    output logic                           err,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           mac_start,
    output logic [VEC_W-1:0]               mac_a_flat,
    output logic [VEC_W-1:0]               mac_b_flat,
    output logic signed [15:0]             mac_bias,
    input  logic signed [15:0]             mac_result,
    input  logic                           mac_done
);

    localparam int DATA_W = 16;
    localparam int GID_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [GID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   wait_cnt;
    logic [GID_W-1:0]   win_id;

    // First asserted request at or above the pointer, wrapping around.
    function automatic logic [GID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [GID_W-1:0]   ptr);
        logic [GID_W-1:0] pick;
        logic [GID_W-1:0] sel;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = GID_W'(idx);
            if (!found && r[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
        return pick;
    endfunction

    assign win_id = rr_pick(req, rr_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            done       <= '0;
            err        <= 1'b0;
            result     <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
            mac_start  <= 1'b0;
            mac_a_flat <= '0;
            mac_b_flat <= '0;
            mac_bias   <= '0;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        mac_a_flat <= req_a_flat[win_id*VEC_W +: VEC_W];
                        mac_b_flat <= req_b_flat[win_id*VEC_W +: VEC_W];
                        mac_bias   <= $signed(req_bias[win_id*DATA_W +: DATA_W]);
                        grant_id   <= win_id;
                        rr_ptr     <= (win_id == GID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                        mac_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mac_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion arriving on the last allowed cycle still counts as success.
                    if (mac_done) begin
                        result <= mac_result;
                        err    <= 1'b0;
                        done   <= NUM_REQ'(1) << grant_id;
                        state  <= S_RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= NUM_REQ'(1) << grant_id;
                        state  <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    done  <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
